// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the serial multiplier: controller
//               state encoding and the default operand width.
// Contents    : state_t       - IDLE / RUN / DONE controller states
//               DEFAULT_WIDTH - default operand width in bits
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_add_stage.sv
`default_nettype none
// ============================================================================
// Module      : mult_add_stage
// Description : WIDTH-bit unsigned ripple-carry adder built from full-adder
//               cells; the carry-out is kept as bit WIDTH of the sum.
// Ports       : x   in  [WIDTH-1:0] - addend (running partial product)
//               y   in  [WIDTH-1:0] - addend (gated multiplicand)
//               sum out [WIDTH:0]   - x + y including carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module mult_add_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end : g_fa

  assign sum[WIDTH] = carry[WIDTH];

endmodule : mult_add_stage
`default_nettype wire

// File: rtl/serial_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_mult_ctrl
// Description : Shift-and-add unsigned multiplier controller. One multiplier
//               bit is consumed per RUN cycle; the result is
//               {acc_hi, mreg} once DONE is reached.
// Ports       : clk     in              - clock, rising edge
//               reset   in              - synchronous active-high reset
//               start   in              - start request, sampled in IDLE
//               a       in  [WIDTH-1:0] - multiplicand
//               b       in  [WIDTH-1:0] - multiplier
//               busy    out             - high in RUN and DONE
//               done    out             - one-cycle completion pulse
//               product out [2*WIDTH-1:0] - result, held until next start
// Options     : SERIAL_MULT_EARLY_TERM_EN - when defined, RUN ends as soon
//               as the unprocessed multiplier bits are all zero, with one
//               final alignment cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  acc_hi;
  logic [WIDTH-1:0]  mreg;
  logic [WIDTH-1:0]  mcand;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH:0]    sum;
  logic              early_done;

  assign addend = mreg[0] ? mcand : '0;

  mult_add_stage #(.WIDTH(WIDTH)) u_add (
    .x   (acc_hi),
    .y   (addend),
    .sum (sum)
  );

`ifdef SERIAL_MULT_EARLY_TERM_EN
  // After 'count' steps the low WIDTH-count bits of mreg are the multiplier
  // bits still to be consumed. Once they are all zero the remaining steps
  // would only shift, so the whole shift is done in one go.
  localparam logic [CW:0] FULL_SHIFT = (CW+1)'(WIDTH);

  logic [WIDTH-1:0]   pending_mask;
  logic [CW:0]        align_shift;
  logic [2*WIDTH-1:0] aligned;

  assign pending_mask = {WIDTH{1'b1}} >> count;
  assign early_done   = (mreg & pending_mask) == '0;
  assign align_shift  = FULL_SHIFT - {1'b0, count};
  assign aligned      = {acc_hi, mreg} >> align_shift;
`else
  assign early_done   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (early_done || (count == LAST_COUNT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi <= '0;
      mreg   <= '0;
      mcand  <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_hi <= '0;
            mreg   <= b;
            mcand  <= a;
            count  <= '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
`ifdef SERIAL_MULT_EARLY_TERM_EN
          if (early_done) begin
            {acc_hi, mreg} <= aligned;
          end else begin
            {acc_hi, mreg} <= {sum, mreg[WIDTH-1:1]};
          end
`else
          // Carry out of the add lands in the MSB of acc_hi; the LSB of the
          // sum drops into the top of mreg as the multiplier shifts out.
          {acc_hi, mreg} <= {sum, mreg[WIDTH-1:1]};
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign product = {acc_hi, mreg};

endmodule : serial_mult_ctrl
`default_nettype wire

// File: tb/tb_serial_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mult_ctrl
// Description : Directed self-checking bench for serial_mult_ctrl with an
//               8-bit and a 64-bit instance. Expected latencies depend on
//               SERIAL_MULT_EARLY_TERM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mult_ctrl;

`ifdef SERIAL_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start8, start64;
  logic [7:0]   a8, b8;
  logic [63:0]  a64, b64;
  logic         busy8, done8, busy64, done64;
  logic [15:0]  product8;
  logic [127:0] product64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  serial_mult_ctrl #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .a(a64), .b(b64),
    .busy(busy64), .done(done64), .product(product64)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one operation on the selected instance and follow it to done.
  // Latency counts cycles from the cycle start is high to the done cycle.
  task automatic run_op(input bit wide, input logic [63:0] av, input logic [63:0] bv,
                        input logic [127:0] exp_p, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    if (wide) begin
      a64 = av; b64 = bv; start64 = 1'b1;
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
    end
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start8  = 1'b0;
      start64 = 1'b0;
      if (wide ? done64 : done8) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check_val({tag, "_prod"}, wide ? product64 : {112'b0, product8}, exp_p);
    @(negedge clk);
    check_val({tag, "_pulse"}, 128'(wide ? done64 : done8), 128'(0));
    check_val({tag, "_idle"}, 128'(wide ? busy64 : busy8), 128'(0));
    check_val({tag, "_hold"}, wide ? product64 : {112'b0, product8}, exp_p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int lat;
    reset = 1'b1; start8 = 1'b0; start64 = 1'b0;
    a8 = '0; b8 = '0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy8", 128'(busy8), 128'(0));
    check_val("rst_done8", 128'(done8), 128'(0));
    check_val("rst_prod8", {112'b0, product8}, 128'(0));
    check_val("rst_busy64", 128'(busy64), 128'(0));
    check_val("rst_prod64", product64, 128'(0));
    reset = 1'b0;

    // 13 * 11 = 143; b = 1011b so early termination finishes after bit 3
    run_op(1'b0, 64'd13, 64'd11, 128'd143, EARLY ? 6 : 9, "m13x11");
    // all-ones operands, full 16-bit result
    run_op(1'b0, 64'd255, 64'd255, 128'h0FE01, 9, "m255x255");
    run_op(1'b0, 64'd9, 64'd0, 128'd0, EARLY ? 2 : 9, "m9x0");
    run_op(1'b0, 64'd9, 64'd1, 128'd9, EARLY ? 3 : 9, "m9x1");
    run_op(1'b0, 64'd0, 64'd255, 128'd0, 9, "m0x255");
    run_op(1'b0, 64'd200, 64'd128, 128'd25600, 9, "m200x128");

    // start held through RUN with new operands: first result unaffected,
    // second operation accepted only once IDLE is re-entered
    @(negedge clk);
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a8 = 8'd7; b8 = 8'd7;
      end
      if (done8) begin
        lat = k;
        break;
      end
    end
    check_val("held_lat1", 128'(lat), 128'(EARLY ? 6 : 9));
    check_val("held_prod1", {112'b0, product8}, 128'd143);
    @(negedge clk);
    check_val("held_idle", 128'(busy8), 128'(0));
    check_val("held_keep", {112'b0, product8}, 128'd143);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check_val("held_lat2", 128'(lat), 128'(EARLY ? 5 : 9));
    check_val("held_prod2", {112'b0, product8}, 128'd49);
    @(negedge clk);

    // reset three cycles into RUN, with a start request in the reset cycle
    @(negedge clk);
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check_val("mid_busy", 128'(busy8), 128'(1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
    @(negedge clk);
    check_val("mid_rst_busy", 128'(busy8), 128'(0));
    check_val("mid_rst_done", 128'(done8), 128'(0));
    check_val("mid_rst_prod", {112'b0, product8}, 128'(0));
    reset = 1'b0; start8 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    check_val("mid_no_done", 128'(seen), 128'(0));
    run_op(1'b0, 64'd6, 64'd5, 128'd30, EARLY ? 5 : 9, "post_rst");

    // 64-bit: all-ones times two
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE,
           EARLY ? 4 : 65, "w64");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_mult_ctrl
`default_nettype wire

// File: doc/serial_mult_ctrl.md
SERIAL_MULT_CTRL -- requirements
Module: serial_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the operand width in bits (legal values 4..64, power of two).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request a new multiply; sampled only in IDLE.
REQ-005 a  input  WIDTH  SHALL be the unsigned multiplicand, captured on the accepted start.
REQ-006 b  input  WIDTH  SHALL be the unsigned multiplier, captured on the accepted start.
REQ-007 busy  output  1  SHALL be high in RUN and DONE.
REQ-008 done  output  1  SHALL be a one-cycle pulse in DONE.
REQ-009 product  output  2*WIDTH  SHALL be the result, valid from done until the next accepted start.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE.
REQ-011 IDLE->RUN SHALL occur when start=1; a, b captured; acc_hi<=0; mreg<=b; mcand<=a; count<=0.
REQ-012 In RUN, each cycle SHALL compute sum = acc_hi + (mreg[0] ? mcand : 0) as WIDTH+1 bits (carry kept) via the shared adder.
REQ-013 In RUN, {acc_hi, mreg} SHALL be loaded with {sum, mreg} shifted right one bit (carry enters acc_hi MSB).
REQ-014 count SHALL increment each RUN cycle; RUN->DONE SHALL occur on the cycle count reaches WIDTH-1.
REQ-015 Without early termination, latency from accepted start to done SHALL be exactly WIDTH+1 cycles.
REQ-016 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-017 product SHALL equal {acc_hi, mreg} and SHALL hold after DONE.
REQ-018 start in RUN or DONE SHALL be ignored; no queuing.
REQ-019 start in the same cycle as reset SHALL be ignored (reset wins).
REQ-020 All-ones operands SHALL produce the full 2*WIDTH product with no overflow loss.
REQ-021 Operand inputs changing after acceptance SHALL not affect the running operation.

Reset
REQ-022 reset SHALL force state=IDLE, busy=0, done=0, product=0, count=0, from any state including mid-RUN.
REQ-023 An operation interrupted by reset SHALL be abandoned with no done pulse.

Configuration
REQ-024 Macro SERIAL_MULT_EARLY_TERM_EN, when defined, SHALL end RUN early once the unprocessed multiplier bits are all zero, shifting the product into final alignment in a single extra RUN cycle.
REQ-025 With SERIAL_MULT_EARLY_TERM_EN, b=0 SHALL give done 2 cycles after the accepted start with product=0; otherwise latency SHALL not exceed WIDTH+1.
REQ-026 Without SERIAL_MULT_EARLY_TERM_EN, latency SHALL be fixed at WIDTH+1 for all operands.

Structure
REQ-027 Shared package mult_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 The WIDTH+1-bit add SHALL be a sub-module mult_add_stage (ripple of the team full-adder cells); the controller SHALL contain only FSM, counter and shift registers.

Verification
REQ-029 WIDTH=8, a=13, b=11, start pulse -> done exactly 9 cycles later, product=143.
REQ-030 WIDTH=8, a=255, b=255 -> product=65025 (0xFE01).
REQ-031 WIDTH=8, start held high during RUN with new a=7, b=7 -> first result 143 unchanged; second operation starts only after IDLE is re-entered.
REQ-032 WIDTH=8, reset asserted 3 cycles into RUN -> next cycle busy=0, product=0, no done pulse; a new start then completes normally.
REQ-033 WIDTH=64, a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> product=0x1_FFFF_FFFF_FFFF_FFFE after 65 cycles.
REQ-034 With SERIAL_MULT_EARLY_TERM_EN, WIDTH=8, a=9, b=0 -> done 2 cycles after start, product=0; a=9, b=1 -> product=9 in under 9 cycles.
